// File: rtl/sram_word_controller_pkg.sv
// Shared definitions for the SRAM word controller: FSM encodings and the address/timing
// defaults that the cache controller also relies on.
package sram_word_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_ADDR_W      = 18;

  // Byte offset of a request relative to the first SRAM-mapped byte (wraps modulo 2^32).
  function automatic logic [31:0] byte_offset(input logic [31:0] address,
                                              input logic [31:0] base);
    return address - base;
  endfunction

endpackage

// File: rtl/sram_word_controller.sv
// Splits one 32-bit read/write into a low then high 16-bit SRAM access, each held on the pins
// for HOLD_CYCLES clocks; ready is low while busy and pulses for one cycle on completion.
module sram_word_controller
  import sram_word_controller_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              ready,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int WORD_W = ADDR_W - 1;
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic              op_wr_q;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req;
  logic              hold_done;
  logic              active;
  logic [31:0]       offset;
  logic [15:0]       dq_out;
  logic              unused_offset;

  assign req       = wr_en | rd_en;
  assign hold_done = (cnt_q == CNT_LAST);
  assign active    = (state == ST_LO) || (state == ST_HI);
  assign offset    = byte_offset(address, 32'(BASE_ADDR));
  // Byte lane bits and anything above the SRAM word range are dropped (modulo wrap).
  assign unused_offset = ^{offset[31:WORD_W+2], offset[1:0]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req)       state_nxt = ST_LO;
      ST_LO:   if (hold_done) state_nxt = ST_HI;
      ST_HI:   if (hold_done) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op_wr_q  <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      readData <= '0;
    end else begin
      state <= state_nxt;
      if (state != state_nxt) cnt_q <= '0;
      else if (active)        cnt_q <= cnt_q + 1'b1;

      if (state == ST_IDLE && req) begin
        op_wr_q <= wr_en;
        word_q  <= offset[WORD_W+1:2];
        wdata_q <= writeData;
      end

      // Sample read data at the end of each half so the SRAM has the full hold window to settle.
      if (!op_wr_q && hold_done) begin
        if (state == ST_LO) readData[15:0]  <= SRAM_DQ;
        if (state == ST_HI) readData[31:16] <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    ready     = (state == ST_DONE) || (state == ST_IDLE && !req);
    SRAM_ADDR = '0;
    if (state == ST_LO) SRAM_ADDR = {word_q, 1'b0};
    if (state == ST_HI) SRAM_ADDR = {word_q, 1'b1};
    SRAM_WE_N = ~(active & op_wr_q);
    SRAM_OE_N = ~(active & ~op_wr_q);
    dq_out    = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign SRAM_DQ = SRAM_WE_N ? 16'bz : dq_out;

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed bench: a small SRAM model on the pins, expected transactions queued at issue time
// and checked by an independent pin monitor when ready closes each access.
module tb_sram_word_controller;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  tri   [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_word_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // SRAM model: 16 half-words, preloaded with 16'hA000+index.
  logic [15:0] mem [16];
  logic        init_done = 1'b0;
  logic        probe_en  = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[3:0]] <= SRAM_DQ;
    end
  end

  // probe_en drives a marker so a floating bus reads back as that marker.
  assign SRAM_DQ = probe_en ? 16'h5A5A :
                   (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[3:0]] : 16'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [17:0] lo_addr;
    logic [15:0] lo_dat;
    logic [15:0] hi_dat;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  // Pin monitor.
  bit          busy, saw_we, saw_oe;
  int          act_cyc, n_acc;
  logic [17:0] acc_addr [4];
  logic [15:0] acc_dat  [4];

  always @(negedge clk) begin
    if (!rst) begin
      busy = 0; saw_we = 0; saw_oe = 0; act_cyc = 0; n_acc = 0;
    end else begin
      if (!SRAM_WE_N || !SRAM_OE_N) begin
        busy = 1;
        act_cyc++;
        if (!SRAM_WE_N) saw_we = 1;
        if (!SRAM_OE_N) saw_oe = 1;
        if (n_acc == 0) begin
          acc_addr[0] = SRAM_ADDR; acc_dat[0] = SRAM_DQ; n_acc = 1;
        end else if (n_acc < 4 && SRAM_ADDR != acc_addr[n_acc-1]) begin
          acc_addr[n_acc] = SRAM_ADDR; acc_dat[n_acc] = SRAM_DQ; n_acc++;
        end
      end
      if (ready && busy) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_we_seen", 32'(saw_we), 32'(e.is_wr));
          chk("sb_oe_seen", 32'(saw_oe), 32'(!e.is_wr));
          chk("sb_active_cycles", act_cyc, 2 * HOLD);
          chk("sb_accesses", n_acc, 2);
          chk("sb_addr_lo", 32'(acc_addr[0]), 32'(e.lo_addr));
          chk("sb_addr_hi", 32'(acc_addr[1]), 32'(e.lo_addr | 18'd1));
          if (e.is_wr) begin
            chk("sb_wdat_lo", 32'(acc_dat[0]), 32'(e.lo_dat));
            chk("sb_wdat_hi", 32'(acc_dat[1]), 32'(e.hi_dat));
          end else begin
            chk("sb_rdata", readData, e.rdata);
          end
        end
        busy = 0; saw_we = 0; saw_oe = 0; act_cyc = 0; n_acc = 0;
      end
    end
  end

  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [17:0] exp_lo,
                       input logic [31:0] exp_rd, input bit change_mid);
    exp_t e;
    int   lat;
    e.is_wr   = wr;
    e.lo_addr = exp_lo;
    e.lo_dat  = wdat[15:0];
    e.hi_dat  = wdat[31:16];
    e.rdata   = exp_rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = addr; writeData = wdat;
    #1 chk("ready_low_on_request", 32'(ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (change_mid && lat == 2) begin
        address   = 32'h0000_0410;
        writeData = 32'hFFFF_FFFF;
      end
      if (ready) break;
    end
    chk("latency", lat, 2 * HOLD + 1);
    wr_en = 0; rd_en = 0;
  endtask

  initial begin
    int k;
    rst = 1'b0; wr_en = 0; rd_en = 0; address = '0; writeData = '0;
    @(posedge clk); #1 init_done = 1'b1;
    @(negedge clk); #1;
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("rst_readdata", readData, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    probe_en = 1'b1; #1;
    chk("rst_dq_released", 32'(SRAM_DQ), 32'h5A5A);
    probe_en = 1'b0;
    @(negedge clk) rst = 1'b1;

    issue(1, 0, 32'd1024, 32'hDEAD_BEEF, 18'd0, 32'd0, 0);
    issue(0, 1, 32'd1024, 32'd0, 18'd0, 32'hDEAD_BEEF, 0);
    issue(1, 1, 32'd1028, 32'hCAFE_F00D, 18'd2, 32'd0, 0);
    issue(0, 1, 32'd1028, 32'd0, 18'd2, 32'hCAFE_F00D, 0);
    issue(1, 0, 32'd1036, 32'h0BAD_C0DE, 18'd6, 32'd0, 1);
    issue(0, 1, 32'd1036, 32'd0, 18'd6, 32'h0BAD_C0DE, 0);
    issue(0, 1, 32'd1040, 32'd0, 18'd8, 32'hA009_A008, 0);
    issue(0, 1, 32'd1020, 32'd0, 18'h3FFFE, 32'hA00F_A00E, 0);
    issue(0, 1, 32'h0008_0400, 32'd0, 18'd0, 32'hDEAD_BEEF, 0);

    // Abort a write once its high half is on the pins.
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1032; writeData = 32'h1234_5678;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (SRAM_ADDR == 18'd5 && !SRAM_WE_N) break;
    end
    chk("reached_hi_phase", 32'(k < 20), 32'd1);
    rst = 1'b0; wr_en = 0; probe_en = 1'b1;
    #1;
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("abort_dq_released", 32'(SRAM_DQ), 32'h5A5A);
    chk("abort_readdata", readData, 32'd0);
    chk("abort_ready_idle", 32'(ready), 32'd1);
    probe_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(0, 1, 32'd1032, 32'd0, 18'd4, 32'hA005_5678, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
